// File: rtl/instruction_fetch_stage.sv
// Program counter plus IF/ID pipeline register feeding a combinational program ROM.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky fetch_misaligned flag for unaligned redirects.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  fetch_misaligned,
`endif
    output logic [DATA_WIDTH-1:0] if_id_instruction
);

    logic [DATA_WIDTH-1:0] pc_reg, pc_next;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  valid_reg, valid_next;
    logic [DATA_WIDTH-1:0] ifid_pc_reg, ifid_pc_next;
    logic [DATA_WIDTH-1:0] ifid_pc4_reg, ifid_pc4_next;
    logic [DATA_WIDTH-1:0] ifid_instr_reg, ifid_instr_next;

    // Wraps naturally at 2^DATA_WIDTH; no overflow indication.
    assign pc_plus4        = pc_reg + DATA_WIDTH'(4);
    assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);

    always_comb begin
        pc_next         = pc_plus4;
        valid_next      = 1'b1;
        ifid_pc_next    = pc_reg;
        ifid_pc4_next   = pc_plus4;
        ifid_instr_next = instr_data;

        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc_reg;
        end

        // A redirect squashes the wrong-path word fetched this cycle, even when stalled.
        if (flush || redirect_valid) begin
            valid_next      = 1'b0;
            ifid_pc_next    = '0;
            ifid_pc4_next   = '0;
            ifid_instr_next = NOP_WORD;
        end else if (stall) begin
            valid_next      = valid_reg;
            ifid_pc_next    = ifid_pc_reg;
            ifid_pc4_next   = ifid_pc4_reg;
            ifid_instr_next = ifid_instr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            valid_reg      <= 1'b0;
            ifid_pc_reg    <= '0;
            ifid_pc4_reg   <= '0;
            ifid_instr_reg <= NOP_WORD;
        end else begin
            pc_reg         <= pc_next;
            valid_reg      <= valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

    assign instr_addr        = pc_reg;
    assign if_id_valid       = valid_reg;
    assign if_id_pc          = ifid_pc_reg;
    assign if_id_pc_plus4    = ifid_pc4_reg;
    assign if_id_instruction = ifid_instr_reg;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_reg, misaligned_next;

    // Sticky: once an unaligned redirect is seen, only reset clears it.
    always_comb begin
        misaligned_next = misaligned_reg;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= misaligned_next;
        end
    end

    assign fetch_misaligned = misaligned_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: two instances (RESET_PC 0 and 0xFFFFFFF8) share stimulus.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_addr, instr_data, if_id_pc, if_id_pc_plus4, if_id_instruction;
    logic        if_id_valid;
    logic [31:0] instr_addr2, instr_data2, if_id_pc2, if_id_pc_plus42, if_id_instruction2;
    logic        if_id_valid2;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned, fetch_misaligned2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ROM contents: a tag in the top byte, the word address below it.
    assign instr_data  = 32'hE500_0000 | instr_addr;
    assign instr_data2 = 32'hE500_0000 | instr_addr2;

    instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .if_id_instruction(if_id_instruction)
    );

    instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP_WORD(32'h0)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_addr(instr_addr2), .instr_data(instr_data2),
        .if_id_valid(if_id_valid2), .if_id_pc(if_id_pc2), .if_id_pc_plus4(if_id_pc_plus42),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misaligned(fetch_misaligned2),
`endif
        .if_id_instruction(if_id_instruction2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One edge, then sample 1ns later so outputs have settled.
    task automatic step(input string name);
        @(posedge clk);
        #1;
        $display("step %-14s pc=%h valid=%b if_pc=%h if_pc4=%h instr=%h",
                 name, instr_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction);
    endtask

    task automatic chk_dut1(input string tag, input logic [31:0] pc, input logic v,
                            input logic [31:0] ipc, input logic [31:0] ipc4, input logic [31:0] ins);
        chk({tag, ".pc"},    instr_addr, pc);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
        chk({tag, ".ifpc"},  if_id_pc, ipc);
        chk({tag, ".ifpc4"}, if_id_pc_plus4, ipc4);
        chk({tag, ".instr"}, if_id_instruction, ins);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset two cycles
        step("reset1");
        step("reset2");
        chk_dut1("rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("rst2.pc", instr_addr2, 32'hFFFF_FFF8);
        chk("rst2.valid", {31'b0, if_id_valid2}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst.mis", {31'b0, fetch_misaligned}, 32'h0);
`endif
        reset = 1'b0;

        step("run1");
        chk_dut1("run1", 32'h4, 1'b1, 32'h0, 32'h4, 32'hE500_0000);
        chk("run1_2.pc", instr_addr2, 32'hFFFF_FFFC);
        chk("run1_2.ifpc", if_id_pc2, 32'hFFFF_FFF8);
        chk("run1_2.instr", if_id_instruction2, 32'hFFFF_FFF8);
        step("run2");
        chk_dut1("run2", 32'h8, 1'b1, 32'h4, 32'h8, 32'hE500_0004);
        chk("run2_2.pc", instr_addr2, 32'h0);
        chk("run2_2.ifpc", if_id_pc2, 32'hFFFF_FFFC);
        chk("run2_2.ifpc4", if_id_pc_plus42, 32'h0);

        // Stall three cycles at PC=0x8
        stall = 1'b1;
        step("stall1");
        chk_dut1("stall1", 32'h8, 1'b1, 32'h4, 32'h8, 32'hE500_0004);
        step("stall2");
        chk_dut1("stall2", 32'h8, 1'b1, 32'h4, 32'h8, 32'hE500_0004);
        step("stall3");
        chk_dut1("stall3", 32'h8, 1'b1, 32'h4, 32'h8, 32'hE500_0004);
        stall = 1'b0;
        step("resume1");
        chk_dut1("resume1", 32'hC, 1'b1, 32'h8, 32'hC, 32'hE500_0008);
        step("resume2");
        chk_dut1("resume2", 32'h10, 1'b1, 32'hC, 32'h10, 32'hE500_000C);

        // Redirect to 0x40 from PC=0x10
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step("redir");
        chk_dut1("redir", 32'h40, 1'b0, 32'h0, 32'h0, 32'h0);
        redirect_valid = 1'b0;
        step("redir_tgt");
        chk_dut1("redir_tgt", 32'h44, 1'b1, 32'h40, 32'h44, 32'hE500_0040);

        // Redirect together with stall
        redirect_valid = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
        step("redir_stall");
        chk_dut1("redir_stall", 32'h20, 1'b0, 32'h0, 32'h0, 32'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        step("after_rs");
        chk_dut1("after_rs", 32'h24, 1'b1, 32'h20, 32'h24, 32'hE500_0020);

        // Steer to 0xC, then flush alone
        redirect_valid = 1'b1; redirect_pc = 32'hC;
        step("redir_c");
        chk_dut1("redir_c", 32'hC, 1'b0, 32'h0, 32'h0, 32'h0);
        redirect_valid = 1'b0; flush = 1'b1;
        step("flush");
        chk_dut1("flush", 32'h10, 1'b0, 32'h0, 32'h0, 32'h0);
        flush = 1'b0;
        step("after_fl");
        chk_dut1("after_fl", 32'h14, 1'b1, 32'h10, 32'h14, 32'hE500_0010);

        // Flush together with stall: bubble, PC holds
        flush = 1'b1; stall = 1'b1;
        step("flush_stall");
        chk_dut1("flush_stall", 32'h14, 1'b0, 32'h0, 32'h0, 32'h0);
        flush = 1'b0; stall = 1'b0;
        step("after_fs");
        chk_dut1("after_fs", 32'h18, 1'b1, 32'h14, 32'h18, 32'hE500_0014);

        // Unaligned redirect target is masked to a word boundary
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step("misalign");
        chk_dut1("misalign", 32'h20, 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign.mis", {31'b0, fetch_misaligned}, 32'h1);
`endif
        redirect_valid = 1'b0;
        step("after_mis");
        chk_dut1("after_mis", 32'h24, 1'b1, 32'h20, 32'h24, 32'hE500_0020);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("sticky.mis", {31'b0, fetch_misaligned}, 32'h1);
`endif

        // Reset mid-stream overrides a concurrent redirect
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step("mid_reset");
        chk_dut1("mid_reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("mid_reset2.pc", instr_addr2, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mid_reset.mis", {31'b0, fetch_misaligned}, 32'h0);
`endif
        reset = 1'b0; redirect_valid = 1'b0;
        step("post_reset");
        chk_dut1("post_reset", 32'h4, 1'b1, 32'h0, 32'h4, 32'hE500_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
